// File: rtl/cp0_exc_ctrl_if.sv
// CP0 register access port: live Status/Cause/EPC/timer reads plus the single CP0 write port.
// Latency: pure wiring, no storage.
// Backpressure: none on this port; the sequencer owns the write port while it runs.
interface cp0_exc_ctrl_if;
  logic [31:0] status_i;
  logic [31:0] cause_i;
  logic [31:0] epc_i;
  logic        timer_int_i;
  logic        cp0_we_o;
  logic [4:0]  cp0_waddr_o;
  logic [31:0] cp0_wdata_o;

  // Exception controller side: reads CP0 state, drives the write port
  modport master (
    input  status_i, cause_i, epc_i, timer_int_i,
    output cp0_we_o, cp0_waddr_o, cp0_wdata_o
  );

  // CP0 register file side
  modport slave (
    output status_i, cause_i, epc_i, timer_int_i,
    input  cp0_we_o, cp0_waddr_o, cp0_wdata_o
  );
endinterface

// File: rtl/cp0_exc_ctrl.sv
// MEM-stage exception/interrupt entry and ERET sequencer; serialises EPC/Status/Cause onto the CP0 write port.
// Latency: entry redirects at T+4 (EPC, Status, Cause writes, then jump); ERET redirects at T+2.
// Backpressure: stall_o holds IF..MEM from the taking cycle until the jump; mtc0 is forwarded only when idle.
module cp0_exc_ctrl #(
  parameter logic [31:0] EXC_VECTOR = 32'h0000_0040,
  parameter logic [4:0]  INT_CODE   = 5'd0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  exc_valid_i,
  input  logic [4:0]            exc_type_i,
  input  logic                  eret_i,
  input  logic [31:0]           pc_i,
  input  logic                  in_delay_slot_i,
  input  logic                  mtc0_we_i,
  input  logic [4:0]            mtc0_addr_i,
  input  logic [31:0]           mtc0_data_i,
  cp0_exc_ctrl_if.master        cp0,
  output logic                  stall_o,
  output logic                  flush_o,
  output logic [31:0]           new_pc_o,
  output logic                  new_pc_valid_o,
  output logic [4:0]            exc_code_o,
  output logic                  busy_o
);

  localparam logic [4:0] ADDR_STATUS = 5'd12;
  localparam logic [4:0] ADDR_CAUSE  = 5'd13;
  localparam logic [4:0] ADDR_EPC    = 5'd14;

  typedef enum logic [2:0] {
    S_IDLE, S_W_EPC, S_W_STAT, S_W_CAUSE, S_JUMP, S_E_STAT
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [31:0] r_epc;
  logic        r_bd;
  logic [4:0]  r_code;
  logic [31:0] r_target;
  logic [4:0]  r_exc_code;

  logic        w_int_take;
  logic        w_exc_take;
  logic        w_eret_take;
  logic        w_entry;
  logic        w_unused_cause;

  // Cause[6:2] is always replaced by the new ExcCode, so its old value is never read
  assign w_unused_cause = ^cp0.cause_i[6:2];

  // Interrupt needs IE set, EXL clear and at least one unmasked pending line (timer rides on IM7)
  assign w_int_take  = exc_valid_i & cp0.status_i[0] & ~cp0.status_i[1] &
                       ((|(cp0.cause_i[15:8] & cp0.status_i[15:8])) |
                        (cp0.timer_int_i & cp0.status_i[15]));
  assign w_exc_take  = ~w_int_take & exc_valid_i & (exc_type_i != 5'd0);
  assign w_eret_take = ~w_int_take & ~w_exc_take & exc_valid_i & eret_i;
  assign w_entry     = w_int_take | w_exc_take;

  assign exc_code_o  = r_exc_code;

  // State register plus latches for the entry context, redirect target and reported ExcCode
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_epc      <= 32'd0;
      r_bd       <= 1'b0;
      r_code     <= 5'd0;
      r_target   <= 32'd0;
      r_exc_code <= 5'd0;
    end else begin
      r_state <= w_next;
      if (r_state == S_IDLE && w_entry) begin
        r_code   <= w_int_take ? INT_CODE : exc_type_i;
        r_bd     <= in_delay_slot_i;
        r_epc    <= in_delay_slot_i ? (pc_i - 32'd4) : pc_i;
        r_target <= EXC_VECTOR;
      end
      if (r_state == S_E_STAT) begin
        r_target <= cp0.epc_i;
      end
      if (r_state == S_W_CAUSE) begin
        r_exc_code <= r_code;
      end
    end
  end

  // Next state and per-state drive of the CP0 write port, stall and redirect; all quiet during reset
  always_comb begin
    w_next          = r_state;
    cp0.cp0_we_o    = 1'b0;
    cp0.cp0_waddr_o = 5'd0;
    cp0.cp0_wdata_o = 32'd0;
    stall_o         = 1'b0;
    flush_o         = 1'b0;
    new_pc_o        = 32'd0;
    new_pc_valid_o  = 1'b0;
    busy_o          = 1'b0;
    if (!rst) begin
      busy_o  = (r_state != S_IDLE);
      stall_o = (r_state != S_IDLE);
      case (r_state)
        S_IDLE: begin
          if (w_entry) begin
            w_next  = S_W_EPC;
            stall_o = 1'b1;
          end else if (w_eret_take) begin
            w_next  = S_E_STAT;
            stall_o = 1'b1;
          end else begin
            cp0.cp0_we_o    = mtc0_we_i;
            cp0.cp0_waddr_o = mtc0_addr_i;
            cp0.cp0_wdata_o = mtc0_data_i;
          end
        end
        S_W_EPC: begin
          cp0.cp0_we_o    = 1'b1;
          cp0.cp0_waddr_o = ADDR_EPC;
          cp0.cp0_wdata_o = r_epc;
          w_next          = S_W_STAT;
        end
        S_W_STAT: begin
          cp0.cp0_we_o    = 1'b1;
          cp0.cp0_waddr_o = ADDR_STATUS;
          cp0.cp0_wdata_o = cp0.status_i | 32'h0000_0002;
          w_next          = S_W_CAUSE;
        end
        S_W_CAUSE: begin
          cp0.cp0_we_o    = 1'b1;
          cp0.cp0_waddr_o = ADDR_CAUSE;
          cp0.cp0_wdata_o = {r_bd, cp0.cause_i[30:7], r_code, cp0.cause_i[1:0]};
          w_next          = S_JUMP;
        end
        S_E_STAT: begin
          cp0.cp0_we_o    = 1'b1;
          cp0.cp0_waddr_o = ADDR_STATUS;
          cp0.cp0_wdata_o = cp0.status_i & ~32'h0000_0002;
          w_next          = S_JUMP;
        end
        S_JUMP: begin
          new_pc_o       = r_target;
          new_pc_valid_o = 1'b1;
          flush_o        = 1'b1;
          w_next         = S_IDLE;
        end
        default: begin
          w_next = S_IDLE;
        end
      endcase
    end
  end

endmodule
